// File: rtl/des_frame_loader.sv
// Byte-to-block front end for the triple-DES core: assembles a header, optional keys and one
// 64-bit data block from received bytes, then hands them to the core with a one-cycle ready.
module des_frame_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        frame_start,
  input  logic        next,
  output logic [63:0] key1,
  output logic [63:0] key2,
  output logic [63:0] block_out,
  output logic        ed_sel,
  output logic        ready,
  output logic        busy,
  output logic        overflow,
  output logic        frame_error
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StKey1,
    StKey2,
    StData,
    StIssue,
    StWaitDone
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          hdr_ed_q, hdr_ed_d;
  logic          hdr_lk_q, hdr_lk_d;
  logic [63:0]   k1_stg_q, k1_stg_d;
  logic [63:0]   k2_stg_q, k2_stg_d;
  logic [63:0]   dat_stg_q, dat_stg_d;
  logic [63:0]   key1_q, key1_d;
  logic [63:0]   key2_q, key2_d;
  logic [63:0]   block_q, block_d;
  logic          ed_sel_q, ed_sel_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_ed_d  = hdr_ed_q;
    hdr_lk_d  = hdr_lk_q;
    k1_stg_d  = k1_stg_q;
    k2_stg_d  = k2_stg_q;
    dat_stg_d = dat_stg_q;
    key1_d    = key1_q;
    key2_d    = key2_q;
    block_d   = block_q;
    ed_sel_d  = ed_sel_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    busy_d    = (state_q == StIssue) || (state_q == StWaitDone);

    unique case (state_q)
      StIdle, StKey1, StKey2, StData: begin
        // frame_start restarts framing; a byte in the same cycle becomes the new header
        if (frame_start || (state_q == StIdle)) begin
          if (frame_start && (state_q != StIdle)) ferr_d = 1'b1;
          cnt_d   = 3'd0;
          state_d = StIdle;
          if (rx_valid) begin
            hdr_ed_d = rx_data[0];
            hdr_lk_d = rx_data[1];
            ovf_d    = 1'b0;
            state_d  = rx_data[1] ? StKey1 : StData;
          end
        end else if (rx_valid) begin
          if (state_q == StKey1) k1_stg_d = {k1_stg_q[55:0], rx_data};
          if (state_q == StKey2) k2_stg_d = {k2_stg_q[55:0], rx_data};
          if (state_q == StData) dat_stg_d = {dat_stg_q[55:0], rx_data};
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
            if (state_q == StKey1)      state_d = StKey2;
            else if (state_q == StKey2) state_d = StData;
            else                        state_d = StIssue;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StIssue: begin
        ready_d = 1'b1;
        if (hdr_lk_q) begin
          key1_d = k1_stg_q;
          key2_d = k2_stg_q;
        end
        block_d  = dat_stg_q;
        ed_sel_d = hdr_ed_q;
        tmo_d    = '0;
        state_d  = StWaitDone;
        if (rx_valid) ovf_d = 1'b1;
      end
      StWaitDone: begin
        if (rx_valid) ovf_d = 1'b1;
        if (next) begin
          state_d = StIdle;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            ferr_d  = 1'b1;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hdr_ed_q  <= 1'b0;
      hdr_lk_q  <= 1'b0;
      k1_stg_q  <= '0;
      k2_stg_q  <= '0;
      dat_stg_q <= '0;
      key1_q    <= '0;
      key2_q    <= '0;
      block_q   <= '0;
      ed_sel_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_ed_q  <= hdr_ed_d;
      hdr_lk_q  <= hdr_lk_d;
      k1_stg_q  <= k1_stg_d;
      k2_stg_q  <= k2_stg_d;
      dat_stg_q <= dat_stg_d;
      key1_q    <= key1_d;
      key2_q    <= key2_d;
      block_q   <= block_d;
      ed_sel_q  <= ed_sel_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      tmo_q     <= tmo_d;
    end
  end

  assign key1        = key1_q;
  assign key2        = key2_q;
  assign block_out   = block_q;
  assign ed_sel      = ed_sel_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_des_frame_loader.sv
// Randomized scoreboard bench for des_frame_loader: stimulus pushes expected core hand-offs and
// error pulses, a negedge monitor pops and compares them.
module tb_des_frame_loader;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_start;
  logic        next;
  logic [63:0] key1, key2, block_out;
  logic        ed_sel, ready, busy, overflow, frame_error;

  des_frame_loader #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_start (frame_start),
    .next        (next),
    .key1        (key1),
    .key2        (key2),
    .block_out   (block_out),
    .ed_sel      (ed_sel),
    .ready       (ready),
    .busy        (busy),
    .overflow    (overflow),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] k1;
    logic [63:0] k2;
    logic [63:0] d;
    logic        ed;
  } exp_t;

  exp_t exp_q[$];
  bit   err_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;

  // reference state: committed keys and sticky overflow
  logic [63:0] m_k1 = '0;
  logic [63:0] m_k2 = '0;
  logic        m_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_ready: got ready=1 expected no hand-off");
        end else begin
          mon_e = exp_q.pop_front();
          check("key1", key1, mon_e.k1);
          check("key2", key2, mon_e.k2);
          check("block_out", block_out, mon_e.d);
          check("ed_sel", {63'd0, ed_sel}, {63'd0, mon_e.ed});
          check("busy_at_ready", {63'd0, busy}, 64'd1);
        end
      end
      if (frame_error === 1'b1) begin
        if (err_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_frame_error: got frame_error=1 expected 0");
        end else begin
          void'(err_q.pop_front());
          check("frame_error_seen", 64'd1, 64'd1 & {63'd0, frame_error});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit fs);
    frame_start = fs;
    rx_valid    = 1'b1;
    rx_data     = b;
    tick();
    rx_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      next = ($urandom_range(0, 3) == 0);  // ignored outside WAIT_DONE
      tick();
      next = 1'b0;
    end
  endtask

  task automatic accept_header(input logic [7:0] hdr, input bit fs);
    check("overflow_before_hdr", {63'd0, overflow}, {63'd0, m_ovf});
    send_byte(hdr, fs);
    check("overflow_after_hdr", {63'd0, overflow}, 64'd0);
    m_ovf = 1'b0;
  endtask

  task automatic partial_frame(input logic [7:0] hdr, input int nbytes);
    accept_header(hdr, 1'b0);
    for (int i = 0; i < nbytes; i++) begin
      gap();
      send_byte(8'($urandom), 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [63:0] k1, input logic [63:0] k2,
                            input logic [63:0] d, input bit fs, input bit err,
                            input bit do_next, input bit inject);
    logic [7:0] bytes[$];
    int         g;
    if (hdr[1]) begin
      for (int j = 7; j >= 0; j--) bytes.push_back(k1[j*8 +: 8]);
      for (int j = 7; j >= 0; j--) bytes.push_back(k2[j*8 +: 8]);
      m_k1 = k1;
      m_k2 = k2;
    end
    for (int j = 7; j >= 0; j--) bytes.push_back(d[j*8 +: 8]);
    if (err) err_q.push_back(1'b1);
    exp_q.push_back('{k1: m_k1, k2: m_k2, d: d, ed: hdr[0]});
    accept_header(hdr, fs);
    foreach (bytes[i]) begin
      gap();
      send_byte(bytes[i], 1'b0);
    end
    check("ready_latency_early", {63'd0, ready}, 64'd0);
    tick();
    check("ready_latency", {63'd0, ready}, 64'd1);
    check("busy_in_issue", {63'd0, busy}, 64'd1);
    if (inject) begin
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      tick();
      rx_valid = 1'b0;
      m_ovf    = 1'b1;
      check("overflow_set", {63'd0, overflow}, 64'd1);
      check("block_hold_ovf", block_out, d);
      check("key1_hold_ovf", key1, m_k1);
    end
    if (do_next) begin
      g = inject ? 0 : $urandom_range(0, 2);
      for (int i = 0; i < g; i++) tick();
      next = 1'b1;
      tick();
      next = 1'b0;
      if (inject) check("overflow_sticky", {63'd0, overflow}, 64'd1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key1"}, key1, 64'd0);
    check({tag, "_key2"}, key2, 64'd0);
    check({tag, "_block"}, block_out, 64'd0);
    check({tag, "_flags"}, {58'd0, ed_sel, ready, busy, overflow, frame_error, 1'b0}, 64'd0);
  endtask

  initial begin
    logic [7:0]  h;
    logic [63:0] d;
    n_rst = 1'b0; rx_data = '0; rx_valid = 1'b0; frame_start = 1'b0; next = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    n_rst = 1'b1;
    tick();

    send_frame(8'h03, 64'h0102030405060708, 64'h1112131415161718, 64'hA0A1A2A3A4A5A6A7,
               1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h00, '0, '0, 64'hFFFEFDFCFBFAF9F8, 1'b0, 1'b0, 1'b1, 1'b0);

    // abort in KEY1; the frame_start byte 0x00 becomes a data-only header
    partial_frame(8'h02, 5);
    send_frame(8'h00, '0, '0, {$urandom, $urandom}, 1'b1, 1'b1, 1'b1, 1'b0);

    send_frame(8'h01, '0, '0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h00, '0, '0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1, 1'b0);

    // core never answers: timeout after 4 cycles in WAIT_DONE
    d = {$urandom, $urandom};
    err_q.push_back(1'b1);
    send_frame(8'h01, '0, '0, d, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("tmo_no_err_early", {63'd0, frame_error}, 64'd0);
    check("tmo_busy_early", {63'd0, busy}, 64'd1);
    tick();
    check("tmo_err_pulse", {63'd0, frame_error}, 64'd1);
    tick();
    check("tmo_busy_drop", {63'd0, busy}, 64'd0);
    check("tmo_err_single", {63'd0, frame_error}, 64'd0);
    check("tmo_block_kept", block_out, d);

    // reset mid-KEY2
    partial_frame(8'h03, 11);
    n_rst = 1'b0;
    tick();
    check_all_zero("midreset");
    n_rst = 1'b1;
    m_k1  = '0;
    m_k2  = '0;
    m_ovf = 1'b0;
    send_frame(8'h01, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               1'b0, 1'b0, 1'b1, 1'b0);

    for (int it = 0; it < 20; it++) begin
      h = 8'($urandom);
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] ph;
        ph = 8'($urandom);
        partial_frame(ph, $urandom_range(0, ph[1] ? 23 : 7));
        send_frame(h, {$urandom, $urandom}, {$urandom, $urandom}, d, 1'b1, 1'b1, 1'b1,
                   ($urandom_range(0, 4) == 0));
      end else begin
        send_frame(h, {$urandom, $urandom}, {$urandom, $urandom}, d,
                   ($urandom_range(0, 4) == 0), 1'b0, 1'b1, ($urandom_range(0, 4) == 0));
      end
    end

    tick(); tick(); tick();
    check("pending_handoffs", 64'(exp_q.size()), 64'd0);
    check("pending_errors", 64'(err_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
